test_driver_binop: RTL and testbench

TEST_DRIVER_BINOP -- requirements
Module: test_driver_binop

---
 rtl/test_pkg.sv | 43 ++++
 rtl/test_lfsr.sv | 22 ++
 rtl/test_driver_binop.sv | 168 ++++++++++++++++
 tb/tb_test_driver_binop.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/test_pkg.sv
// Shared definitions for the binary-operator test driver: operation and FSM
// encodings, the LFSR step function and the golden reference operation.
package test_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form).
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

  // Second generator is decorrelated from the first by this seed offset.
  localparam logic [31:0] SEED_B_XOR = 32'hA5A5_A5A5;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  // Reference result at full 32-bit width; callers keep the low WIDTH bits,
  // which makes the add wrap modulo 2^WIDTH.
  function automatic logic [31:0] golden_op(input op_e op,
                                            input logic [31:0] x,
                                            input logic [31:0] z);
    logic [31:0] r;
    case (op)
      OP_AND:  r = x & z;
      OP_OR:   r = x | z;
      OP_XOR:  r = x ^ z;
      default: r = x + z;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/test_lfsr.sv
// 32-bit Galois LFSR operand generator, reseeded by reset, stepped by en.
module test_lfsr
  import test_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] q
);

  // Reseed on reset, otherwise advance one step per enabled cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= SEED;
    end else if (en) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/test_driver_binop.sv
// Stimulus driver and checker for a binary-operator DUT: presents directed
// then pseudo-random operand pairs, compares the DUT result against the
// golden op after LAT cycles, and reports sticky fail/finish plus a
// saturating mismatch count.
module test_driver_binop
  import test_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int          OP      = 0,
  parameter int          NUM_VEC = 16,
  parameter int          LAT     = 0,
  parameter logic [31:0] SEED    = 32'h0000_0001
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             fail,
  output logic             finish,
  output logic [15:0]      err_count
);

  localparam op_e         OP_SEL     = op_e'(OP[1:0]);
  localparam logic [16:0] NUM_VEC_K  = 17'(NUM_VEC);
  localparam logic [3:0]  LAST_DRAIN = 4'(LAT - 1);

  state_e           state, state_nxt;
  logic [16:0]      k, k_nxt;
  logic [3:0]       drain_cnt, drain_cnt_nxt;

  logic             load_vec;
  logic             lfsr_en;
  logic             cmp_en;
  logic             mismatch;
  logic             enter_done;
  logic [WIDTH-1:0] vec_a, vec_b;
  logic [31:0]      exp_full;
  logic [31:0]      lfsr_a_q, lfsr_b_q;

  logic [WIDTH-1:0] pipe_exp [0:LAT];
  logic             pipe_v   [0:LAT];

  // Only the low WIDTH bits of the generators and golden result are used.
  logic             unused_ok;
  assign unused_ok = ^{lfsr_a_q, lfsr_b_q, exp_full};

  test_lfsr #(
    .SEED(SEED)
  ) u_lfsr_a (
    .clock (clock),
    .reset (reset),
    .en    (lfsr_en),
    .q     (lfsr_a_q)
  );

  test_lfsr #(
    .SEED(SEED ^ SEED_B_XOR)
  ) u_lfsr_b (
    .clock (clock),
    .reset (reset),
    .en    (lfsr_en),
    .q     (lfsr_b_q)
  );

  // FSM state, vector index and drain counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_RUN;
      k         <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state logic. RUN stays put for the cycle in which the last vector is
  // presented, so DRAIN covers exactly the LAT cycles of remaining latency and
  // the move into DONE coincides with the final comparison.
  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    drain_cnt_nxt = drain_cnt;
    case (state)
      ST_RUN: begin
        if (k < NUM_VEC_K) begin
          k_nxt = k + 17'd1;
        end else begin
          state_nxt     = (LAT == 0) ? ST_DONE : ST_DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == LAST_DRAIN) begin
          state_nxt = ST_DONE;
        end else begin
          drain_cnt_nxt = drain_cnt + 4'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Output decode: vector selection, generator stepping and compare enables.
  always_comb begin
    load_vec = (state == ST_RUN) && (k < NUM_VEC_K);
    lfsr_en  = load_vec && (k >= 17'd4);
    vec_a    = '0;
    vec_b    = '0;
    if (load_vec) begin
      case (k)
        17'd0: begin
        end
        17'd1: vec_a = '1;
        17'd2: vec_b = '1;
        17'd3: begin
          vec_a = '1;
          vec_b = '1;
        end
        default: begin
          vec_a = lfsr_a_q[WIDTH-1:0];
          vec_b = lfsr_b_q[WIDTH-1:0];
        end
      endcase
    end
    exp_full   = golden_op(OP_SEL, 32'(vec_a), 32'(vec_b));
    cmp_en     = (state != ST_DONE) && pipe_v[LAT];
    mismatch   = cmp_en && (y != pipe_exp[LAT]);
    enter_done = (state != ST_DONE) && (state_nxt == ST_DONE);
  end

  // Operand registers, expected-value pipeline and sticky result flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      a         <= '0;
      b         <= '0;
      fail      <= 1'b0;
      finish    <= 1'b0;
      err_count <= '0;
      for (int unsigned i = 0; i <= LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_exp[i] <= '0;
      end
    end else begin
      a           <= vec_a;
      b           <= vec_b;
      pipe_v[0]   <= load_vec;
      pipe_exp[0] <= exp_full[WIDTH-1:0];
      for (int unsigned i = 1; i <= LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
      end
      if (mismatch) begin
        fail <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + 16'd1;
        end
      end
      if (enter_done) begin
        finish <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_test_driver_binop.sv
// Directed bench for test_driver_binop: several driver configurations run in
// parallel against small behavioural DUTs (correct, stuck, mis-timed, always
// wrong), plus a mid-sequence reset on one instance.
module tb_test_driver_binop;

  logic clock;
  logic rst;
  logic rst5;

  int checks   = 0;
  int failures = 0;
  int edge_n   = -1;

  logic [31:0] ma [16];
  logic [31:0] mb [16];
  int          exp_err2;

  // u0: WIDTH1 AND, LAT0, 4 vectors, combinational AND DUT
  logic       a0, b0, y0, fail0, fin0;
  logic [15:0] err0;
  // u1: WIDTH8 ADD, LAT2, registered adder with 2-cycle latency
  logic [7:0] a1, b1, y1, r1a, r1b;
  logic       fail1, fin1;
  logic [15:0] err1;
  // u2: WIDTH8 XOR, LAT1, DUT stuck at 0
  logic [7:0] a2, b2, y2;
  logic       fail2, fin2;
  logic [15:0] err2;
  // u3: WIDTH4 OR, LAT3, DUT with latency 2
  logic [3:0] a3, b3, y3, r3a, r3b;
  logic       fail3, fin3;
  logic [15:0] err3;
  // u4: WIDTH8 AND, LAT0, 65535 vectors, DUT always wrong
  logic [7:0] a4, b4, y4;
  logic       fail4, fin4;
  logic [15:0] err4;
  // u5: WIDTH8 XOR, LAT1, correct registered DUT, own reset
  logic [7:0] a5, b5, y5, r5;
  logic       fail5, fin5;
  logic [15:0] err5;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  assign y0 = a0 & b0;
  assign y1 = r1b;
  assign y2 = 8'h00;
  assign y3 = r3b;
  assign y4 = ~(a4 & b4);
  assign y5 = r5;

  always @(posedge clock) begin
    if (rst) begin
      r1a <= '0; r1b <= '0; r3a <= '0; r3b <= '0;
    end else begin
      r1a <= a1 + b1; r1b <= r1a;
      r3a <= a3 | b3; r3b <= r3a;
    end
  end

  always @(posedge clock) begin
    if (rst5) r5 <= '0;
    else      r5 <= a5 ^ b5;
  end

  test_driver_binop #(.WIDTH(1), .OP(0), .NUM_VEC(4), .LAT(0), .SEED(32'h1)) u0 (
    .clock(clock), .reset(rst), .a(a0), .b(b0), .y(y0),
    .fail(fail0), .finish(fin0), .err_count(err0));
  test_driver_binop #(.WIDTH(8), .OP(3), .NUM_VEC(16), .LAT(2), .SEED(32'h1)) u1 (
    .clock(clock), .reset(rst), .a(a1), .b(b1), .y(y1),
    .fail(fail1), .finish(fin1), .err_count(err1));
  test_driver_binop #(.WIDTH(8), .OP(2), .NUM_VEC(16), .LAT(1), .SEED(32'h1)) u2 (
    .clock(clock), .reset(rst), .a(a2), .b(b2), .y(y2),
    .fail(fail2), .finish(fin2), .err_count(err2));
  test_driver_binop #(.WIDTH(4), .OP(1), .NUM_VEC(16), .LAT(3), .SEED(32'h1)) u3 (
    .clock(clock), .reset(rst), .a(a3), .b(b3), .y(y3),
    .fail(fail3), .finish(fin3), .err_count(err3));
  test_driver_binop #(.WIDTH(8), .OP(0), .NUM_VEC(65535), .LAT(0), .SEED(32'h1)) u4 (
    .clock(clock), .reset(rst), .a(a4), .b(b4), .y(y4),
    .fail(fail4), .finish(fin4), .err_count(err4));
  test_driver_binop #(.WIDTH(8), .OP(2), .NUM_VEC(16), .LAT(1), .SEED(32'h1)) u5 (
    .clock(clock), .reset(rst5), .a(a5), .b(b5), .y(y5),
    .fail(fail5), .finish(fin5), .err_count(err5));

  function automatic logic [31:0] adv(input logic [31:0] s);
    logic [31:0] r;
    r = {1'b0, s[31:1]};
    if (s[0]) begin
      r[31] = ~r[31];
      r[21] = ~r[21];
      r[1]  = ~r[1];
      r[0]  = ~r[0];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    edge_n++;
  endtask

  initial begin
    logic [31:0] sa, sb;
    sa = 32'h0000_0001;
    sb = 32'h0000_0001 ^ 32'hA5A5_A5A5;
    for (int k = 0; k < 16; k++) begin
      case (k)
        0: begin ma[k] = 32'h0;          mb[k] = 32'h0;          end
        1: begin ma[k] = 32'hFFFF_FFFF;  mb[k] = 32'h0;          end
        2: begin ma[k] = 32'h0;          mb[k] = 32'hFFFF_FFFF;  end
        3: begin ma[k] = 32'hFFFF_FFFF;  mb[k] = 32'hFFFF_FFFF;  end
        default: begin
          ma[k] = sa;
          mb[k] = sb;
          sa = adv(sa);
          sb = adv(sb);
        end
      endcase
    end
    exp_err2 = 0;
    for (int k = 0; k < 16; k++) begin
      if (((ma[k] ^ mb[k]) & 32'hFF) != 32'h0) exp_err2++;
    end

    rst  = 1'b1;
    rst5 = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_a0", a0, 0);
    check("rst_b0", b0, 0);
    check("rst_a1", a1, 0);
    check("rst_fail0", fail0, 0);
    check("rst_fin0", fin0, 0);
    check("rst_err1", err1, 0);
    check("rst_fin5", fin5, 0);
    rst  = 1'b0;
    rst5 = 1'b0;

    for (int e = 0; e <= 30; e++) begin
      tick();
      if (e < 4) begin
        check("u0_a", a0, ma[e] & 32'h1);
        check("u0_b", b0, mb[e] & 32'h1);
      end
      if (e == 3) check("u0_fin_early", fin0, 0);
      if (e == 4) begin
        check("u0_fin", fin0, 1);
        check("u0_fail", fail0, 0);
        check("u0_err", err0, 0);
      end
      if (e < 16) begin
        check("u1_a", a1, ma[e] & 32'hFF);
        check("u1_b", b1, mb[e] & 32'hFF);
      end
      if (e == 16) begin
        check("u1_a_drain", a1, 0);
        check("u1_b_drain", b1, 0);
      end
      if (e == 17) check("u1_fin_early", fin1, 0);
      if (e == 18) begin
        check("u1_fin", fin1, 1);
        check("u1_fail", fail1, 0);
        check("u1_err", err1, 0);
      end
      if (e == 2) check("u2_fail_early", fail2, 0);
      if (e == 3) check("u2_fail", fail2, 1);
      if (e == 16) check("u2_fin_early", fin2, 0);
      if (e == 17) begin
        check("u2_fin", fin2, 1);
        check("u2_err", err2, 32'(exp_err2));
      end
      if (e == 30) check("u2_err_frozen", err2, 32'(exp_err2));
      if (e == 18) check("u3_fin_early", fin3, 0);
      if (e == 19) begin
        check("u3_fin", fin3, 1);
        check("u3_fail", fail3, 1);
      end
      if (e == 10) check("u4_err_partial", err4, 10);
      if (e <= 7) begin
        check("u5_a_run1", a5, ma[e] & 32'hFF);
        check("u5_b_run1", b5, mb[e] & 32'hFF);
      end
      if (e == 7) rst5 = 1'b1;
      if (e == 8) begin
        check("u5_rst_a", a5, 0);
        check("u5_rst_b", b5, 0);
        check("u5_rst_fail", fail5, 0);
        check("u5_rst_fin", fin5, 0);
        check("u5_rst_err", err5, 0);
        rst5 = 1'b0;
      end
      if (e >= 9 && e <= 24) begin
        check("u5_a_run2", a5, ma[e-9] & 32'hFF);
        check("u5_b_run2", b5, mb[e-9] & 32'hFF);
      end
      if (e == 25) check("u5_fin_early", fin5, 0);
      if (e == 26) begin
        check("u5_fin", fin5, 1);
        check("u5_fail", fail5, 0);
        check("u5_err", err5, 0);
      end
    end

    while (edge_n < 65534) tick();
    check("u4_fin_early", fin4, 0);
    check("u4_err_pre", err4, 32'hFFFE);
    tick();
    check("u4_fin", fin4, 1);
    check("u4_fail", fail4, 1);
    check("u4_err_sat", err4, 32'hFFFF);
    repeat (5) tick();
    check("u4_err_hold", err4, 32'hFFFF);
    check("u3_fin_hold", fin3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
